ysyx_22040386_ifu_fetch_buffer: RTL

//  Fetch stage sitting directly upstream of the IDU. Issues 8-byte-aligned requests on the imem

---
 rtl/ysyx_22040386_fb_pkg.sv | 27 ++
 rtl/ysyx_22040386_fb_fifo.sv | 70 +++++++
 rtl/ysyx_22040386_ifu_fetch_buffer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ysyx_22040386_fb_pkg.sv
// Shared types and constants for the IFU fetch buffer.
package ysyx_22040386_fb_pkg;

    typedef enum logic [2:0] {
        FB_IDLE  = 3'd0,
        FB_REQ   = 3'd1,
        FB_RESP  = 3'd2,
        FB_DRAIN = 3'd3,
        FB_HALT  = 3'd4
    } fb_state_e;

    localparam logic [31:0] FB_NOP      = 32'h0000_0013;
    localparam logic [63:0] FB_RESET_PC = 64'h0000_0000_8000_0000;
    localparam int          FB_ENTRY_W  = 97;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fb_entry_t;

    // A doubleword holds two instructions; pc[2] picks the upper or lower word.
    function automatic logic [31:0] fb_select_inst(input logic [63:0] pc, input logic [63:0] data);
        return pc[2] ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/ysyx_22040386_fb_fifo.sv
// Synchronous FIFO with push, pop and flush; flush wins over push and pop.
module ysyx_22040386_fb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 97
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ysyx_22040386_ifu_fetch_buffer.sv
// IFU fetch buffer: one-outstanding imem fetcher feeding a small decode queue.
// Optional YSYX_22040386_FB_PERF_EN adds fetch/flush event counters.
module ysyx_22040386_ifu_fetch_buffer
    import ysyx_22040386_fb_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = FB_RESET_PC
) (
    input  logic        i_FB_clk,
    input  logic        i_FB_rst_n,
    input  logic        i_FB_Branch,
    input  logic [63:0] i_FB_dnpc,
    output logic        o_FB_imem_req_valid,
    input  logic        i_FB_imem_req_ready,
    output logic [63:0] o_FB_imem_req_addr,
    input  logic        i_FB_imem_rsp_valid,
    input  logic [63:0] i_FB_imem_rsp_data,
    input  logic        i_FB_imem_rsp_err,
    output logic        o_FB_valid,
    input  logic        i_FB_ready,
    output logic [63:0] o_FB_pc,
    output logic [31:0] o_FB_inst,
    output logic        o_FB_fault,
`ifdef YSYX_22040386_FB_PERF_EN
    output logic [63:0] o_FB_perf_fetch,
    output logic [63:0] o_FB_perf_flush,
`endif
    output fb_state_e   o_FB_dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = DEPTH[AW+1:0];

    // Handshakes: imem request fires on req_valid & req_ready; the decode
    // side pops on o_FB_valid & i_FB_ready; a redirect suppresses that pop.
    fb_state_e   state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;

    logic        req_hs, push, pop;
    logic [AW:0] fifo_count;
    logic        fifo_full, fifo_empty;
    logic [AW+1:0] count_after;
    fb_entry_t   push_entry, head;
    logic [1:0]  unused_dnpc_lsb;

    assign unused_dnpc_lsb = i_FB_dnpc[1:0];

    assign req_hs = (state_q == FB_REQ) && i_FB_imem_req_ready;
    assign push   = (state_q == FB_RESP) && i_FB_imem_rsp_valid && !i_FB_Branch;
    assign pop    = !fifo_empty && i_FB_ready && !i_FB_Branch;
    assign count_after = {1'b0, fifo_count} + {{(AW+1){1'b0}}, push} - {{(AW+1){1'b0}}, pop};

    assign push_entry.pc    = fetch_pc_q;
    assign push_entry.inst  = i_FB_imem_rsp_err ? FB_NOP : fb_select_inst(fetch_pc_q, i_FB_imem_rsp_data);
    assign push_entry.fault = i_FB_imem_rsp_err;

    ysyx_22040386_fb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FB_ENTRY_W)
    ) u_fifo (
        .clk_i   (i_FB_clk),
        .rst_ni  (i_FB_rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (i_FB_Branch),
        .wdata_i (push_entry),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            FB_IDLE:  if (!fifo_full) state_d = FB_REQ;
            FB_REQ:   if (req_hs) state_d = FB_RESP;
            FB_RESP: begin
                if (i_FB_imem_rsp_valid) begin
                    fetch_pc_d = fetch_pc_q + 64'd4;
                    if (i_FB_imem_rsp_err)          state_d = FB_HALT;
                    else if (count_after < DEPTH_W) state_d = FB_REQ;
                    else                            state_d = FB_IDLE;
                end
            end
            FB_DRAIN: if (i_FB_imem_rsp_valid) state_d = FB_REQ;
            FB_HALT:  state_d = FB_HALT;
            default:  state_d = FB_IDLE;
        endcase
        // Redirect overrides everything; a response already owed must still be drained.
        if (i_FB_Branch) begin
            fetch_pc_d = {i_FB_dnpc[63:2], 2'b00};
            case (state_q)
                FB_REQ:   state_d = req_hs ? FB_DRAIN : FB_REQ;
                FB_RESP,
                FB_DRAIN: state_d = i_FB_imem_rsp_valid ? FB_REQ : FB_DRAIN;
                default:  state_d = FB_REQ;
            endcase
        end
    end

    always_ff @(posedge i_FB_clk or negedge i_FB_rst_n) begin
        if (!i_FB_rst_n) begin
            state_q    <= FB_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign o_FB_imem_req_valid = (state_q == FB_REQ);
    assign o_FB_imem_req_addr  = (state_q == FB_REQ) ? {fetch_pc_q[63:3], 3'b000} : 64'd0;
    assign o_FB_valid          = !fifo_empty;
    assign o_FB_pc             = fifo_empty ? 64'd0 : head.pc;
    assign o_FB_inst           = fifo_empty ? 32'd0 : head.inst;
    assign o_FB_fault          = !fifo_empty && head.fault;
    assign o_FB_dbg_state      = state_q;

`ifdef YSYX_22040386_FB_PERF_EN
    logic [63:0] perf_fetch_q, perf_flush_q;
    logic        flush_event;

    assign flush_event = i_FB_Branch &&
                         (!fifo_empty || req_hs || (state_q == FB_RESP) || (state_q == FB_DRAIN));

    always_ff @(posedge i_FB_clk or negedge i_FB_rst_n) begin
        if (!i_FB_rst_n) begin
            perf_fetch_q <= 64'd0;
            perf_flush_q <= 64'd0;
        end else begin
            if (push)        perf_fetch_q <= perf_fetch_q + 64'd1;
            if (flush_event) perf_flush_q <= perf_flush_q + 64'd1;
        end
    end

    assign o_FB_perf_fetch = perf_fetch_q;
    assign o_FB_perf_flush = perf_flush_q;
`endif

endmodule
